// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Decodes a multiplexed active-low 7-segment scan bus back into a
//            hex word, with per-digit dwell filtering and bad-pattern flags.
// Revision : 1.0
// ============================================================================
module seg_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic [6:0]          iSEG,
    input  logic [NDIG-1:0]     iDIG_EN,
    output logic [4*NDIG-1:0]   oVALUE,
    output logic                oVALID,
    output logic [NDIG-1:0]     oERR
);

    localparam int c_CNT_W = $clog2(STABLE + 1);
    localparam int c_IDX_W = $clog2(NDIG);

    logic [1:0]             r_rst_sync;
    logic                   w_rst_n;
    logic [6:0]             r_seg;
    logic [NDIG-1:0]        r_en;
    logic [6:0]             r_prev_seg;
    logic [NDIG-1:0]        r_prev_en;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [4*NDIG-1:0]      r_slot;
    logic [NDIG-1:0]        r_slot_err;
    logic [NDIG-1:0]        r_seen;

    logic [NDIG-1:0]        w_low;
    logic                   w_sel_ok;
    logic                   w_same;
    logic                   w_capture;
    logic [NDIG-1:0]        w_cap_mask;
    logic [c_IDX_W-1:0]     w_idx;
    logic [3:0]             w_nib;
    logic                   w_known;

    // Release of reset is re-timed to clk; assertion stays asynchronous.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_low      = ~r_en;
    assign w_sel_ok   = (w_low != '0) &&
                        ((w_low & (w_low - {{(NDIG-1){1'b0}}, 1'b1})) == '0);
    assign w_same     = (r_seg == r_prev_seg) && (r_en == r_prev_en);
    assign w_capture  = w_sel_ok && w_same && (r_cnt == c_CNT_W'(STABLE - 1));
    assign w_cap_mask = w_capture ? w_low : '0;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (w_low[i]) begin
                w_idx = c_IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_nib   = 4'h0;
        w_known = 1'b1;
        case (r_seg)
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h10: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
            default: w_known = 1'b0;
        endcase
    end

    always_ff @(posedge iCLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_seg      <= '0;
            r_en       <= '0;
            r_prev_seg <= '0;
            r_prev_en  <= '0;
            r_cnt      <= '0;
            r_slot     <= '0;
            r_slot_err <= '0;
            r_seen     <= '0;
            oVALUE     <= '0;
            oVALID     <= 1'b0;
            oERR       <= '0;
        end else begin
            r_seg      <= iSEG;
            r_en       <= iDIG_EN;
            r_prev_seg <= r_seg;
            r_prev_en  <= r_en;

            if (!w_sel_ok) begin
                r_cnt <= '0;
            end else if (!w_same) begin
                r_cnt <= c_CNT_W'(1);
            end else if (r_cnt != c_CNT_W'(STABLE)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (w_capture) begin
                if (w_known) begin
                    r_slot[{w_idx, 2'b00} +: 4] <= w_nib;
                    r_slot_err[w_idx]           <= 1'b0;
                end else begin
                    r_slot_err[w_idx]           <= 1'b1;
                end
            end

            // A capture on the publishing edge opens the next frame.
            if (&r_seen) begin
                oVALUE <= r_slot;
                oERR   <= r_slot_err;
                oVALID <= 1'b1;
                r_seen <= w_cap_mask;
            end else begin
                oVALID <= 1'b0;
                r_seen <= r_seen | w_cap_mask;
            end
        end
    end

endmodule
`default_nettype wire
